// File: rtl/instr_mem_if.sv
// Load and fetch bundle between the fetch stage (master) and the instruction memory (slave).
interface instr_mem_if #(
   parameter int unsigned ADDRESS_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32
);
   logic                     load_start;
   logic                     load_valid;
   logic [DATA_WIDTH-1:0]    load_data;
   logic                     load_last;
   logic                     load_ready;
   logic                     load_done;
   logic                     fetch_req;
   logic [ADDRESS_WIDTH+1:0] fetch_addr;
   logic [DATA_WIDTH-1:0]    instr;
   logic                     instr_valid;
   logic                     misaligned;

   modport master (
      output load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
      input  load_ready, load_done, instr, instr_valid, misaligned
   );

   modport slave (
      input  load_start, load_valid, load_data, load_last, fetch_req, fetch_addr,
      output load_ready, load_done, instr, instr_valid, misaligned
   );
endinterface

// File: rtl/instr_mem.sv
// Loadable instruction memory: NOP-clears after reset, streams a program in,
// serves word-aligned byte-addressed fetches with one-cycle registered latency.
module instr_mem #(
   parameter int unsigned          ADDRESS_WIDTH = 5,
   parameter int unsigned          DATA_WIDTH    = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD     = DATA_WIDTH'(32'h0000_0013)
) (
   input logic         clk,
   input logic         rst,
   instr_mem_if.slave  bus
);
   localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] PTR_MAX = '1;

   typedef enum logic [1:0] {CLEAR, RUN, LOAD} state_t;

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] ptr;
   logic [DATA_WIDTH-1:0]    mem [DEPTH];
   logic                     we;
   logic [DATA_WIDTH-1:0]    wdata;
   logic [ADDRESS_WIDTH-1:0] word_idx;
   logic                     addr_off;

   // Shared write port: clear fill or accepted load word, always at ptr.
   always_comb begin
      we       = 1'b0;
      wdata    = NOP_WORD;
      word_idx = bus.fetch_addr[ADDRESS_WIDTH+1:2];
      addr_off = |bus.fetch_addr[1:0];
      if (!rst) begin
         if (state == CLEAR) begin
            we = 1'b1;
         end else if (state == LOAD && bus.load_valid) begin
            we    = 1'b1;
            wdata = bus.load_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= CLEAR;
         ptr             <= '0;
         bus.instr       <= NOP_WORD;
         bus.instr_valid <= 1'b0;
         bus.misaligned  <= 1'b0;
         bus.load_ready  <= 1'b0;
         bus.load_done   <= 1'b0;
      end else begin
         bus.instr_valid <= 1'b0;
         bus.misaligned  <= 1'b0;
         bus.load_done   <= 1'b0;
         case (state)
            CLEAR: begin
               // ptr wraps to zero on the final word, ready for the next load
               ptr <= ptr + ADDRESS_WIDTH'(1);
               if (ptr == PTR_MAX) state <= RUN;
            end
            RUN: begin
               if (bus.fetch_req) begin
                  bus.instr_valid <= 1'b1;
                  bus.misaligned  <= addr_off;
                  bus.instr       <= addr_off ? NOP_WORD : mem[word_idx];
               end
               if (bus.load_start) begin
                  state          <= LOAD;
                  ptr            <= '0;
                  bus.load_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (bus.load_valid) begin
                  ptr <= ptr + ADDRESS_WIDTH'(1);
                  if (bus.load_last || ptr == PTR_MAX) begin
                     state          <= RUN;
                     ptr            <= '0;
                     bus.load_ready <= 1'b0;
                     bus.load_done  <= 1'b1;
                  end
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end
endmodule

// File: doc/instr_mem.md
# instr_mem

Parametrised, loadable instruction memory for the RISC-V core's fetch stage. It clears itself to NOPs after reset, then accepts a program over a streaming load port. It serves byte-addressed, word-aligned fetches with one-cycle registered latency, a valid flag and misalignment detection.

## Interface

Parameters:
- `ADDRESS_WIDTH`, 5: word-address bits; depth = 2^ADDRESS_WIDTH words.
- `DATA_WIDTH`, 32: instruction word width.
- `NOP_WORD`, 32'h00000013: fill value written during clear (`addi x0, x0, 0`).

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `load_start`, in, 1: request to begin a program load.
- `load_valid`, in, 1: `load_data` is valid this cycle.
- `load_data`, in, DATA_WIDTH: word to write.
- `load_last`, in, 1: qualifies the current load word as the final one.
- `load_ready`, out, 1: block accepts load words; high only in LOAD.
- `load_done`, out, 1: one-cycle pulse when LOAD exits.
- `fetch_req`, in, 1: fetch request.
- `fetch_addr`, in, ADDRESS_WIDTH+2: byte address; word index = `fetch_addr[ADDRESS_WIDTH+1:2]`.
- `instr`, out, DATA_WIDTH: fetched instruction, registered.
- `instr_valid`, out, 1: `instr` answers the request from the previous cycle.
- `misaligned`, out, 1: the previous request had `fetch_addr[1:0] != 0`.

## Operation

- Storage: 2^ADDRESS_WIDTH × DATA_WIDTH array. One write port (clear/load) and one registered read port.
- Single ADDRESS_WIDTH-bit write pointer `ptr`, shared by CLEAR and LOAD.

FSM states: CLEAR, RUN, LOAD.

- **CLEAR**
  - Entered on `rst`, with `ptr` = 0.
  - Each cycle writes `NOP_WORD` to `mem[ptr]` and increments `ptr`.
  - After writing word 2^ADDRESS_WIDTH−1, goes to RUN with `ptr` = 0.
  - `load_start` and `fetch_req` are ignored.
- **RUN**
  - Fetches are served.
  - `load_start` = 1 moves to LOAD next cycle and sets `ptr` = 0.
- **LOAD**
  - `load_ready` = 1. Each cycle with `load_valid` high writes `load_data` to `mem[ptr]` and increments `ptr`.
  - LOAD exits to RUN when an accepted word has `load_last` = 1, or when word 2^ADDRESS_WIDTH−1 is written (memory full).
  - On exit, `load_done` = 1 for exactly the following cycle. Words not written keep their previous contents.
  - `load_start` is ignored in LOAD.
  - `load_valid` with `load_ready` = 0 is dropped; there is no buffering.

Fetch (RUN only):
- On a request, next cycle: `instr_valid` = 1 and `misaligned` = (`fetch_addr[1:0] != 0`).
- `instr` = `mem[word index]` when aligned. `instr` = `NOP_WORD` when misaligned.
- Upper address bits index modulo depth; there are no out-of-range addresses.
- No request, or a request in CLEAR or LOAD: next cycle `instr_valid` = 0 and `misaligned` = 0, and `instr` holds its last value.

Simultaneous events:
- `fetch_req` and `load_start` in the same RUN cycle: the fetch is served from pre-load contents, then LOAD is entered.
- `rst` overrides everything at any point, including mid-LOAD. Memory is re-cleared and partial loads are lost.

## Timing

- Reset values (cycle after `rst` is sampled high): `instr` = `NOP_WORD`, `instr_valid` = 0, `misaligned` = 0, `load_ready` = 0, `load_done` = 0, state CLEAR, `ptr` = 0.
- CLEAR lasts exactly 2^ADDRESS_WIDTH cycles after `rst` deasserts. The first fetch can be issued on cycle 2^ADDRESS_WIDTH.
- Fetch latency: 1 cycle, with a throughput of one fetch per cycle.
- Load: 1 word per cycle. `load_ready` rises the cycle after `load_start`.
- `load_done` pulses the cycle after the final write. Fetches are accepted from that same cycle and see the newly written data.
- `ptr` wraps at 2^ADDRESS_WIDTH−1 → 0, and the wrap always coincides with leaving CLEAR or LOAD.

## Test plan

- **Reset/clear:** `rst` for 2 cycles, wait 32 cycles, fetch addrs 0, 4, 124 → `instr` = 32'h00000013 with `instr_valid` = 1 each time. Fetches during clear → `instr_valid` = 0.
- **Load and run:**
  - Stimulus: `load_start`, then words 00100513, 00150513, 0000006f, with `load_last` on the third.
  - Required: `load_done` pulses once. Fetch 0, 4, 8, 12 → 00100513, 00150513, 0000006f, 00000013.
  - Required: back-to-back fetches give `instr_valid` high every cycle.
- **Misaligned:** fetch addr 6 → `misaligned` = 1, `instr` = 00000013, `instr_valid` = 1. Then addr 4 → `misaligned` = 0 and the correct word.
- **Full load:** 32 words with value = index and no `load_last` → `load_done` after word 31, `load_ready` drops. Fetch 124 → 31, fetch 128 → wraps to word 0 → 0.
- **Reset mid-load:** after 2 words written, assert `rst` → after 32 clear cycles, addrs 0 and 4 read 00000013 and `load_done` never pulses.
- **Concurrency/drop:** `fetch_req` and `load_start` in the same cycle → old word returned. Fetch during LOAD → `instr_valid` = 0. `load_start` inside LOAD has no effect on `ptr`.
